// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: opcode values, instruction
// field positions and the fetch state encoding.
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam int PC_W    = 8;
  localparam int OP_W    = 4;
  localparam int REG_W   = 2;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;
  localparam int TGT_MSB = 3;
  localparam int TGT_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_JNZ = 4'b1011;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Signals between the fetch unit, the program store and the execute stage.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [PC_W-1:0]    linenumber;
  logic [INSTR_W-1:0] instr_in;
  logic               exec_ready;
  logic               z_flag;
  logic               dec_valid;
  logic [OP_W-1:0]    dec_op;
  logic [REG_W-1:0]   dec_rd;
  logic [REG_W-1:0]   dec_rs;
  logic               halted;

  modport master (
    output linenumber, dec_valid, dec_op, dec_rd, dec_rs, halted,
    input  instr_in, exec_ready, z_flag
  );

  modport slave (
    input  linenumber, dec_valid, dec_op, dec_rd, dec_rs, halted,
    output instr_in, exec_ready, z_flag
  );

endinterface

// File: rtl/instr_decode.sv
// Splits an instruction byte into its fields and flags the opcodes that the
// fetch unit consumes itself rather than issuing.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic [OP_W-1:0]    o_op,
  output logic [REG_W-1:0]   o_rd,
  output logic [REG_W-1:0]   o_rs,
  output logic [3:0]         o_target,
  output logic               o_is_nop,
  output logic               o_is_jmp,
  output logic               o_is_jnz,
  output logic               o_is_hlt
);

  always_comb begin
    o_op     = i_instr[OP_MSB:OP_LSB];
    o_rd     = i_instr[RD_MSB:RD_LSB];
    o_rs     = i_instr[RS_MSB:RS_LSB];
    o_target = i_instr[TGT_MSB:TGT_LSB];
    o_is_nop = (o_op == OP_NOP);
    o_is_jmp = (o_op == OP_JMP);
    o_is_jnz = (o_op == OP_JNZ);
    o_is_hlt = (o_op == OP_HLT);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: reads one program line, then either issues it to the
// execute stage with a valid/ready handshake or resolves it locally.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int LAST_LINE = 64
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam logic [PC_W-1:0] LAST_PC = LAST_LINE[PC_W-1:0];

  fetch_state_e       r_state;
  fetch_state_e       w_next_state;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_next;
  logic [INSTR_W-1:0] r_ir;
  logic [INSTR_W-1:0] w_ir_next;

  logic [OP_W-1:0]    w_op;
  logic [REG_W-1:0]   w_rd;
  logic [REG_W-1:0]   w_rs;
  logic [3:0]         w_target;
  logic               w_is_nop;
  logic               w_is_jmp;
  logic               w_is_jnz;
  logic               w_is_hlt;
  logic               w_is_issued;
  logic [PC_W-1:0]    w_pc_adv;
  logic [PC_W-1:0]    w_pc_jump;

  instr_decode u_decode (
    .i_instr  (r_ir),
    .o_op     (w_op),
    .o_rd     (w_rd),
    .o_rs     (w_rs),
    .o_target (w_target),
    .o_is_nop (w_is_nop),
    .o_is_jmp (w_is_jmp),
    .o_is_jnz (w_is_jnz),
    .o_is_hlt (w_is_hlt)
  );

  // Wrap only at LAST_LINE; a jump target past it counts on up to 255 -> 0.
  assign w_pc_adv    = (r_pc == LAST_PC) ? '0 : r_pc + 8'd1;
  assign w_pc_jump   = {4'b0000, w_target};
  assign w_is_issued = ~(w_is_nop | w_is_jmp | w_is_jnz | w_is_hlt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    case (r_state)
      ST_FETCH: begin
        w_ir_next    = bus.instr_in;
        w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_is_nop) begin
          w_pc_next    = w_pc_adv;
          w_next_state = ST_FETCH;
        end else if (w_is_jmp) begin
          w_pc_next    = w_pc_jump;
          w_next_state = ST_FETCH;
        end else if (w_is_jnz) begin
          // z_flag is only trusted once the execute stage reports idle.
          if (bus.exec_ready) begin
            w_pc_next    = bus.z_flag ? w_pc_adv : w_pc_jump;
            w_next_state = ST_FETCH;
          end
        end else if (w_is_hlt) begin
          if (bus.exec_ready) begin
            w_next_state = ST_HALT;
          end
        end else if (bus.exec_ready) begin
          w_pc_next    = w_pc_adv;
          w_next_state = ST_FETCH;
        end
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  always_comb begin
    bus.linenumber = r_pc;
    bus.dec_valid  = (r_state == ST_ISSUE) && w_is_issued;
    bus.dec_op     = w_op;
    bus.dec_rd     = w_rd;
    bus.dec_rs     = w_rs;
    bus.halted     = (r_state == ST_HALT);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: LAST_LINE, default 64, highest valid program line; PC wraps to 0 after it.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: linenumber  output  8  program line address driven to the program store.
REQ-005 Port: instr_in  input  8  instruction returned combinationally by the program store for linenumber.
REQ-006 Port: exec_ready  input  1  execute stage idle, able to accept, and z_flag current.
REQ-007 Port: z_flag  input  1  zero flag from execute stage.
REQ-008 Port: dec_valid  output  1  decoded instruction presented to execute stage.
REQ-009 Port: dec_op  output  4  opcode, instr[7:4].
REQ-010 Port: dec_rd  output  2  destination register, instr[3:2].
REQ-011 Port: dec_rs  output  2  source register or 2-bit immediate, instr[1:0].
REQ-012 Port: halted  output  1  HLT executed; fetch stopped.

Function
REQ-013 Opcodes: 0000 NOP, 1011 JNZ, 1100 JMP, 1111 HLT are consumed internally; all others are issued to the execute stage.
REQ-014 States: FETCH, ISSUE, HALT.
REQ-015 FETCH: linenumber = PC; at the clock edge instr_in is captured into the instruction register; next state ISSUE; FETCH always lasts exactly one cycle.
REQ-016 ISSUE, issued opcode: dec_valid=1, fields held stable from the instruction register; on the edge with dec_valid&exec_ready, PC advances and the next state is FETCH.
REQ-017 dec_valid shall never deassert in ISSUE before acceptance; fields shall not change while dec_valid=1.
REQ-018 ISSUE, NOP: dec_valid=0; PC advances; next state FETCH (2 cycles per NOP).
REQ-019 ISSUE, JMP: dec_valid=0; PC = {4'b0, instr[3:0]}; next state FETCH; no wait on exec_ready.
REQ-020 ISSUE, JNZ: dec_valid=0; waits until exec_ready=1; at that edge PC = {4'b0, instr[3:0]} if z_flag=0, otherwise PC advances; next state FETCH.
REQ-021 ISSUE, HLT: waits until exec_ready=1; then the next state is HALT; halted=1 from the following cycle.
REQ-022 HALT: dec_valid=0, PC frozen, halted=1; only rst exits.
REQ-023 PC advance: PC = 0 if PC == LAST_LINE, else PC + 1; 8-bit, no other wrap.
REQ-024 Jump target beyond LAST_LINE: honoured as given; advance from such a PC wraps only at 255->0.
REQ-025 Steady-state throughput: one issued instruction per 2 cycles when exec_ready is held at 1.

Reset
REQ-026 At a rising edge with rst=1: PC=0, state=FETCH, instruction register=0, dec_valid=0, dec_op/dec_rd/dec_rs=0, halted=0.
REQ-027 Reset has priority over every state, including mid-handshake and HALT; a pending dec_valid drops in the cycle after the reset edge, and the pending instruction is discarded.
REQ-028 First fetch after reset release reads line 0.

Structure
REQ-029 Shared package cpu_pkg holds opcode constants, the instruction field bit positions, and the fetch state enumeration.
REQ-030 A combinational sub-module instr_decode splits the instruction and produces is_nop, is_jmp, is_jnz, and is_hlt; the FSM and PC live in fetch_unit.

Verification
REQ-031 Program 10001011,10000110,00011001, exec_ready=1 -> linenumber 0,0,1,1,2,2,3; dec_valid carries op 1000/rd 10/rs 11, then 1000/01/10, then 0001/10/01.
REQ-032 Line 0 = 10001011, exec_ready held 0 for 5 cycles -> dec_valid stays 1 with fields stable; accepted on the cycle exec_ready rises; linenumber 1 on the next cycle.
REQ-033 Line 8 = 11000001 -> no dec_valid for the JMP; linenumber 1 two cycles after it is fetched.
REQ-034 JNZ 10110100 with z_flag=0 -> next linenumber 4; with z_flag=1 -> next linenumber 9 (JNZ at 8); exec_ready low delays the decision.
REQ-035 PC=64 issued with LAST_LINE=64 -> next linenumber 0; line 5 = 11110000 -> halted=1, linenumber frozen at 5 until rst.
REQ-036 rst asserted while dec_valid=1 awaiting exec_ready -> next cycle dec_valid=0, linenumber=0, halted=0, FETCH.
